// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: program counter, one-hot opcodes,
// fetch FSM states and the CBF/CBB nesting-depth type.
package fetch_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 9;
    localparam int NEST_W_DEFAULT = 8;

    typedef logic [PC_W-1:0]    PROGRAM_COUNTER;
    typedef logic [INSTR_W-1:0] INSTRUCTION;
    typedef logic [NEST_W_DEFAULT-1:0] NEST_DEPTH;

    typedef enum logic [INSTR_W-1:0] {
        NOP = 9'h000,
        INC = 9'h001,
        DEC = 9'h002,
        MVR = 9'h004,
        MVL = 9'h008,
        PSH = 9'h010,
        POP = 9'h020,
        CBF = 9'h040,
        CBB = 9'h080,
        HLT = 9'h100
    } op_code;

    typedef enum logic {
        FETCH_PASS,
        FETCH_SKIP
    } FETCH_STATE;

    // Anything other than NOP or a single set bit is not a valid opcode.
    function automatic logic is_illegal(input INSTRUCTION i);
        return (i != '0) && ((i & (i - 1'b1)) != '0);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small prefetch FIFO holding returned instructions; flush wins over push and pop,
// and a pushed entry becomes visible at the head one cycle later.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [8:0]       push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [8:0]       head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    INSTRUCTION       mem_q [DEPTH];
    INSTRUCTION       mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && count_q == CNT_W'(DEPTH)));
    assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && count_q == '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem reads, buffers returned instructions,
// hands them to the decoder and scans forward past a taken CBF to its matching CBB.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int NEST_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [8:0]  imem_rdata,
    output logic        instr_valid,
    output logic [8:0]  instr,
    output logic [15:0] instr_pc,
    output logic        instr_illegal,
    input  logic        instr_ready,
    input  logic        skip_start,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    input  logic        halt,
    output logic        skip_busy,
    output logic        skip_overflow
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0] count;
    INSTRUCTION       head;
    logic             push, pop, flush;

    FETCH_STATE       state_q, state_d;
    PROGRAM_COUNTER   fetch_pc_q, fetch_pc_d;
    PROGRAM_COUNTER   deliver_pc_q, deliver_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] kill_q, kill_d;
    logic [CNT_W-1:0] outstanding_rsp;
    logic [NEST_W-1:0] depth_q, depth_d;
    logic             overflow_q, overflow_d;
    logic             in_pass, has_head, deliver, scan, fire;
    logic [CNT_W:0]   occupancy;

    fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (imem_rdata),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count)
    );

    assign in_pass         = (state_q == FETCH_PASS);
    assign has_head        = (count != '0);
    assign deliver         = in_pass && has_head && instr_ready;
    assign scan            = !in_pass && has_head;
    assign occupancy       = {1'b0, count} + {1'b0, outstanding_q};
    assign outstanding_rsp = outstanding_q - CNT_W'(imem_rvalid);

    // Gated by rst_n so no request is visible while the unit is held in reset.
    assign imem_req  = rst_n && !halt && !pc_load && (occupancy < CAP);
    assign fire      = imem_req && imem_gnt;
    assign imem_addr = fetch_pc_q;

    assign instr_valid   = in_pass && has_head;
    assign instr         = instr_valid ? head : INSTRUCTION'(NOP);
    assign instr_pc      = deliver_pc_q;
    assign instr_illegal = instr_valid && is_illegal(head);
    assign skip_busy     = !in_pass;
    assign skip_overflow = overflow_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        deliver_pc_d  = deliver_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        depth_d       = depth_q;
        overflow_d    = overflow_q;
        push          = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;

        if (pc_load) begin
            // Every request still in flight after this cycle belongs to the old stream.
            flush         = 1'b1;
            fetch_pc_d    = pc_target;
            deliver_pc_d  = pc_target;
            state_d       = FETCH_PASS;
            depth_d       = '0;
            outstanding_d = outstanding_rsp;
            kill_d        = outstanding_rsp;
        end else begin
            if (imem_rvalid) begin
                if (kill_q != '0) begin
                    kill_d = kill_q - 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            outstanding_d = outstanding_rsp + CNT_W'(fire);
            if (fire) begin
                fetch_pc_d = fetch_pc_q + 1'b1;
            end

            if (deliver || scan) begin
                pop          = 1'b1;
                deliver_pc_d = deliver_pc_q + 1'b1;
            end
            if (deliver && skip_start && head == INSTRUCTION'(CBF)) begin
                state_d = FETCH_SKIP;
                depth_d = NEST_W'(1);
            end
            if (scan) begin
                if (head == INSTRUCTION'(CBF)) begin
                    if (depth_q == '1) begin
                        overflow_d = 1'b1;
                    end else begin
                        depth_d = depth_q + 1'b1;
                    end
                end else if (head == INSTRUCTION'(CBB)) begin
                    depth_d = depth_q - 1'b1;
                    if (depth_q == NEST_W'(1)) begin
                        state_d = FETCH_PASS;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_PASS;
            fetch_pc_q    <= '0;
            deliver_pc_q  <= '0;
            outstanding_q <= '0;
            kill_q        <= '0;
            depth_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            deliver_pc_q  <= deliver_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            depth_q       <= depth_d;
            overflow_q    <= overflow_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (outstanding_q != '0));

endmodule
